// File: rtl/cfg_boot_seq.sv
// SoC boot sequencer: latches the UFM config word, then drives reset, straps and run/reboot.
// Optional CFG_BOOT_SEQ_PWRGOOD_EN adds a pwr_good input that gates and restarts the reset phase.
module cfg_boot_seq #(
  parameter logic [4:0]  BASE_ADDR        = 5'h0,
  parameter logic [15:0] RST_CYCLES       = 16'd1000,
  parameter logic [15:0] HOLD_CYCLES      = 16'd64,
  parameter logic [1:0]  DEFAULT_BOOT_SRC = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg,
  input  logic        cfg_done,
`ifdef CFG_BOOT_SEQ_PWRGOOD_EN
  input  logic        pwr_good,
`endif
  output logic        cfg_start,
  input  logic [4:0]  csr_a,
  input  logic [7:0]  csr_di,
  input  logic        csr_we,
  output logic [7:0]  csr_do,
  output logic        soc_rst_n,
  output logic [1:0]  strap,
  output logic        strap_oe,
  output logic        wdt_en
);

  typedef enum logic [2:0] {
    WAIT_CFG    = 3'd0,
    ASSERT_RST  = 3'd1,
    STRAP_HOLD  = 3'd2,
    RUN         = 3'd3,
    RELOAD_REQ  = 3'd4,
    RELOAD_WAIT = 3'd5
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] latched_q;
  logic        erased_q;
  logic        done_low_q;
  logic        soc_rst_n_q;
  logic [1:0]  strap_q;
  logic        strap_oe_q;
  logic        cfg_start_q;
  logic        wdt_en_q;

  logic        erased_d;
  logic [1:0]  src_d;
  logic        wdt_d;
  logic        latch_now;
  logic        reboot;
  logic        pwr_lost;
  logic        cnt_run;
  logic [1:0]  boot_src;
  logic        status_rst;
  logic        unused_ok;

  assign erased_d = (cfg == 16'hFFFF);
  assign src_d    = erased_d ? DEFAULT_BOOT_SRC : cfg[1:0];
  assign wdt_d    = !erased_d && cfg[2];
  assign boot_src = erased_q ? DEFAULT_BOOT_SRC : latched_q[1:0];

  // A reload only completes on a done that was seen low first, so a stale done is not accepted.
  assign latch_now = cfg_done &&
                     ((state_q == WAIT_CFG) || ((state_q == RELOAD_WAIT) && done_low_q));
  assign reboot    = csr_we && (csr_a == BASE_ADDR) && csr_di[0] && (state_q == RUN);

`ifdef CFG_BOOT_SEQ_PWRGOOD_EN
  assign pwr_lost   = !pwr_good && ((state_q == STRAP_HOLD) || (state_q == RUN));
  assign cnt_run    = pwr_good;
  assign status_rst = pwr_good && soc_rst_n_q;
`else
  assign pwr_lost   = 1'b0;
  assign cnt_run    = 1'b1;
  assign status_rst = soc_rst_n_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_CFG;
      cnt_q       <= '0;
      latched_q   <= '0;
      erased_q    <= 1'b0;
      done_low_q  <= 1'b0;
      soc_rst_n_q <= 1'b0;
      strap_q     <= '0;
      strap_oe_q  <= 1'b0;
      cfg_start_q <= 1'b0;
      wdt_en_q    <= 1'b0;
    end else if (latch_now) begin
      latched_q   <= cfg;
      erased_q    <= erased_d;
      wdt_en_q    <= wdt_d;
      strap_q     <= src_d;
      strap_oe_q  <= 1'b1;
      soc_rst_n_q <= 1'b0;
      done_low_q  <= 1'b0;
      cnt_q       <= RST_CYCLES - 16'd1;
      state_q     <= ASSERT_RST;
    end else if (pwr_lost) begin
      soc_rst_n_q <= 1'b0;
      strap_oe_q  <= 1'b1;
      cnt_q       <= RST_CYCLES - 16'd1;
      state_q     <= ASSERT_RST;
    end else begin
      cfg_start_q <= 1'b0;
      case (state_q)
        WAIT_CFG: begin
          soc_rst_n_q <= 1'b0;
          strap_oe_q  <= 1'b0;
        end
        ASSERT_RST: begin
          if (!cnt_run) begin
            cnt_q <= RST_CYCLES - 16'd1;
          end else if (cnt_q == '0) begin
            cnt_q       <= HOLD_CYCLES - 16'd1;
            soc_rst_n_q <= 1'b1;
            state_q     <= STRAP_HOLD;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STRAP_HOLD: begin
          if (cnt_q == '0) begin
            strap_oe_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        RUN: begin
          if (reboot) begin
            soc_rst_n_q <= 1'b0;
            cfg_start_q <= 1'b1;
            done_low_q  <= 1'b0;
            state_q     <= RELOAD_REQ;
          end
        end
        RELOAD_REQ: begin
          state_q <= RELOAD_WAIT;
        end
        RELOAD_WAIT: begin
          if (!cfg_done) done_low_q <= 1'b1;
        end
        default: begin
          soc_rst_n_q <= 1'b0;
          strap_oe_q  <= 1'b0;
          state_q     <= WAIT_CFG;
        end
      endcase
    end
  end

  always_comb begin
    csr_do = '0;
    if (csr_a == BASE_ADDR) begin
      csr_do = {3'(state_q), erased_q, boot_src, wdt_en_q, status_rst};
    end else if (csr_a == BASE_ADDR + 5'd1) begin
      csr_do = latched_q[7:0];
    end
  end

  assign unused_ok = ^{csr_di[7:1], latched_q[15:8]};

  assign soc_rst_n = soc_rst_n_q;
  assign strap     = strap_q;
  assign strap_oe  = strap_oe_q;
  assign cfg_start = cfg_start_q;
  assign wdt_en    = wdt_en_q;

endmodule

// File: tb/tb_cfg_boot_seq.sv
// Directed bench for cfg_boot_seq: boot, reboot/reload, erased word, async reset, optional pwr_good.
module tb_cfg_boot_seq;

  localparam logic [4:0] SB = 5'h08;
  localparam logic [4:0] SC = 5'h09;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg;
  logic        cfg_done;
  logic        pwr_good;
  logic        cfg_start;
  logic [4:0]  csr_a;
  logic [7:0]  csr_di;
  logic        csr_we;
  logic [7:0]  csr_do;
  logic        soc_rst_n;
  logic [1:0]  strap;
  logic        strap_oe;
  logic        wdt_en;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cfg_boot_seq #(
    .BASE_ADDR       (SB),
    .RST_CYCLES      (16'd10),
    .HOLD_CYCLES     (16'd4),
    .DEFAULT_BOOT_SRC(2'b10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (cfg),
    .cfg_done (cfg_done),
`ifdef CFG_BOOT_SEQ_PWRGOOD_EN
    .pwr_good (pwr_good),
`endif
    .cfg_start(cfg_start),
    .csr_a    (csr_a),
    .csr_di   (csr_di),
    .csr_we   (csr_we),
    .csr_do   (csr_do),
    .soc_rst_n(soc_rst_n),
    .strap    (strap),
    .strap_oe (strap_oe),
    .wdt_en   (wdt_en)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_csr(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    check(tag, {8'h00, csr_do}, {8'h00, exp});
  endtask

  task automatic reboot_wr(input logic [7:0] d);
    csr_a  = SB;
    csr_di = d;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg = 16'h0005; cfg_done = 1'b0; pwr_good = 1'b1;
    csr_a = SB; csr_di = 8'h00; csr_we = 1'b0;
    repeat (2) tick();
    check("rst_soc", {15'd0, soc_rst_n}, 16'd0);
    check("rst_strap", {14'd0, strap}, 16'd0);
    check("rst_oe", {15'd0, strap_oe}, 16'd0);
    check("rst_start", {15'd0, cfg_start}, 16'd0);
    check("rst_wdt", {15'd0, wdt_en}, 16'd0);
    chk_csr("rst_status", SB, 8'h00);
    chk_csr("rst_cfglo", SC, 8'h00);

    rst_n = 1'b1;
    repeat (3) tick();
    check("wait_soc", {15'd0, soc_rst_n}, 16'd0);
    check("wait_oe", {15'd0, strap_oe}, 16'd0);

    // boot with 0x0005
    cfg_done = 1'b1;
    tick();
    check("b1_oe", {15'd0, strap_oe}, 16'd1);
    check("b1_strap", {14'd0, strap}, 16'd1);
    check("b1_wdt", {15'd0, wdt_en}, 16'd1);
    chk_csr("b1_st_assert", SB, 8'h26);
    repeat (9) tick();
    check("b1_rst_last_low", {15'd0, soc_rst_n}, 16'd0);
    tick();
    check("b1_rst_rise", {15'd0, soc_rst_n}, 16'd1);
    chk_csr("b1_st_hold", SB, 8'h47);
    repeat (3) tick();
    check("b1_oe_last", {15'd0, strap_oe}, 16'd1);
    check("b1_strap_hold", {14'd0, strap}, 16'd1);
    tick();
    check("b1_oe_drop", {15'd0, strap_oe}, 16'd0);
    chk_csr("b1_st_run", SB, 8'h67);
    chk_csr("b1_cfglo", SC, 8'h05);
    chk_csr("b1_other_addr", 5'h0A, 8'h00);
    chk_csr("b1_addr0", 5'h00, 8'h00);
    cfg = 16'h1234;
    repeat (2) tick();
    chk_csr("b1_cfg_ignored", SC, 8'h05);

    // reboot and reload 0x0002
    reboot_wr(8'h01);
    check("rb_soc", {15'd0, soc_rst_n}, 16'd0);
    check("rb_start", {15'd0, cfg_start}, 16'd1);
    chk_csr("rb_st_req", SB, 8'h86);
    tick();
    check("rb_start_one", {15'd0, cfg_start}, 16'd0);
    chk_csr("rb_st_wait", SB, 8'hA6);
    tick();
    chk_csr("rb_stale_done", SB, 8'hA6);
    cfg_done = 1'b0; cfg = 16'h0002;
    repeat (26) tick();
    chk_csr("rb_still_wait", SB, 8'hA6);
    check("rb_soc_wait", {15'd0, soc_rst_n}, 16'd0);
    cfg_done = 1'b1;
    tick();
    check("b2_strap", {14'd0, strap}, 16'd2);
    check("b2_wdt", {15'd0, wdt_en}, 16'd0);
    check("b2_oe", {15'd0, strap_oe}, 16'd1);
    chk_csr("b2_st", SB, 8'h28);
    chk_csr("b2_cfglo", SC, 8'h02);
    repeat (9) tick();
    check("b2_low", {15'd0, soc_rst_n}, 16'd0);
    tick();
    check("b2_rise", {15'd0, soc_rst_n}, 16'd1);
    repeat (2) tick();
    reboot_wr(8'h01);
    check("b2_hold_reboot_start", {15'd0, cfg_start}, 16'd0);
    chk_csr("b2_hold_reboot_st", SB, 8'h49);
    check("b2_hold_oe", {15'd0, strap_oe}, 16'd1);
    tick();
    check("b2_run_oe", {15'd0, strap_oe}, 16'd0);
    chk_csr("b2_st_run", SB, 8'h69);
    reboot_wr(8'hFE);
    check("b2_bit0_clear_start", {15'd0, cfg_start}, 16'd0);
    chk_csr("b2_bit0_clear_st", SB, 8'h69);

    // reload an erased word
    reboot_wr(8'h01);
    tick();
    tick();
    cfg_done = 1'b0; cfg = 16'hFFFF;
    repeat (3) tick();
    cfg_done = 1'b1;
    tick();
    check("er_strap", {14'd0, strap}, 16'd2);
    check("er_wdt", {15'd0, wdt_en}, 16'd0);
    chk_csr("er_st", SB, 8'h38);
    chk_csr("er_cfglo", SC, 8'hFF);

    // async reset mid ASSERT_RST
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_soc", {15'd0, soc_rst_n}, 16'd0);
    check("ar_strap", {14'd0, strap}, 16'd0);
    check("ar_oe", {15'd0, strap_oe}, 16'd0);
    check("ar_wdt", {15'd0, wdt_en}, 16'd0);
    check("ar_start", {15'd0, cfg_start}, 16'd0);
    chk_csr("ar_st", SB, 8'h00);
    chk_csr("ar_cfglo", SC, 8'h00);
    cfg = 16'h0007;
    rst_n = 1'b1;
    tick();
    chk_csr("b3_st", SB, 8'h2E);
    check("b3_strap", {14'd0, strap}, 16'd3);
    repeat (9) tick();
    check("b3_low", {15'd0, soc_rst_n}, 16'd0);
    tick();
    check("b3_rise", {15'd0, soc_rst_n}, 16'd1);
    repeat (4) tick();
    check("b3_oe_drop", {15'd0, strap_oe}, 16'd0);
    chk_csr("b3_st_run", SB, 8'h6F);

`ifdef CFG_BOOT_SEQ_PWRGOOD_EN
    pwr_good = 1'b0;
    tick();
    check("pg_soc", {15'd0, soc_rst_n}, 16'd0);
    check("pg_oe", {15'd0, strap_oe}, 16'd1);
    chk_csr("pg_st", SB, 8'h2E);
    repeat (5) tick();
    chk_csr("pg_frozen", SB, 8'h2E);
    pwr_good = 1'b1;
    repeat (9) tick();
    check("pg_low", {15'd0, soc_rst_n}, 16'd0);
    tick();
    check("pg_rise", {15'd0, soc_rst_n}, 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
